alu_muldiv: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. Adds signed/unsigned compare, XOR/NOR, signed overflow detection, and an iterative multiply/divide unit with HI/LO registers. All operations are launched with a start/done handshake so the control FSM can stall on long operations. It sits in the EX stage, with the `ALUcontrol` encoding extended to cover MIPS MULT/DIV/MFHI/MFLO.

---
 rtl/alu_muldiv.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU with start/done handshake, iterative shift-add multiplier and
// restoring divider feeding HI/LO. Define ALU_DIV_EN to build the divider.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_out_q, dbz_out_d;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0] b_inv, add_res, sub_res, alu_res;
    logic             alu_ovf;
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             last;

    // Single-cycle operations, evaluated directly on the live operands.
    always_comb begin
        b_inv   = ~B;
        add_res = A + B;
        sub_res = A + b_inv + WIDTH'(1);
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUcontrol)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (A[WIDTH-1] == b_inv[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_DIV, OP_DIVU: alu_res = '0;
            default: alu_res = '0;
        endcase

        is_signed = (ALUcontrol == OP_MULT) || (ALUcontrol == OP_DIV);
        a_neg     = is_signed && A[WIDTH-1];
        b_neg     = is_signed && B[WIDTH-1];
        mag_a     = a_neg ? -A : A;
        mag_b     = b_neg ? -B : B;
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Multiply step: {work_hi, work_lo} holds the running product over the
    // multiplier, shifted right one bit per cycle.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_p, mul_prod;

    always_comb begin
        mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_p    = {mul_sum, work_lo_q[WIDTH-1:1]};
        mul_prod = neg_lo_q ? -mul_p : mul_p;
    end

`ifdef ALU_DIV_EN
    // Divide step: work_hi is the partial remainder, work_lo shifts the
    // dividend out and the quotient in.
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] div_r, div_q, div_quo, div_rem;

    always_comb begin
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_r     = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_q     = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        div_quo   = neg_lo_q ? -div_q : div_q;
        div_rem   = neg_hi_q ? -div_r : div_r;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        neg_lo_d  = neg_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dbz_out_d = dbz_out_q;
`ifdef ALU_DIV_EN
        dvd_d     = dvd_q;
        neg_hi_d  = neg_hi_q;
        dbz_d     = dbz_q;
`endif
        case (state_q)
            S_MUL: begin
                work_hi_d = mul_p[2*WIDTH-1:WIDTH];
                work_lo_d = mul_p[WIDTH-1:0];
                cnt_d     = cnt_q + CW'(1);
                if (last) begin
                    hi_d      = mul_prod[2*WIDTH-1:WIDTH];
                    lo_d      = mul_prod[WIDTH-1:0];
                    result_d  = mul_prod[WIDTH-1:0];
                    zero_d    = (mul_prod[WIDTH-1:0] == '0);
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                work_hi_d = div_r;
                work_lo_d = div_q;
                cnt_d     = cnt_q + CW'(1);
                if (last) begin
                    hi_d      = dbz_q ? dvd_q : div_rem;
                    lo_d      = dbz_q ? '1 : div_quo;
                    result_d  = dbz_q ? '1 : div_quo;
                    zero_d    = !dbz_q && (div_quo == '0);
                    ovf_d     = 1'b0;
                    dbz_out_d = dbz_q;
                    state_d   = S_DONE;
                end
            end
`endif
            default: begin
                // IDLE and DONE both accept a new start since busy is low.
                state_d = S_IDLE;
                if (start) begin
                    case (ALUcontrol)
                        OP_MULT, OP_MULTU: begin
                            state_d   = S_MUL;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = mag_b;
                            opnd_d    = mag_a;
                            neg_lo_d  = a_neg ^ b_neg;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_DIV;
                            cnt_d     = '0;
                            work_hi_d = '0;
                            work_lo_d = mag_a;
                            opnd_d    = mag_b;
                            neg_lo_d  = a_neg ^ b_neg;
                            neg_hi_d  = a_neg;
                            dvd_d     = A;
                            dbz_d     = (B == '0);
                        end
`endif
                        default: begin
                            state_d   = S_DONE;
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            ovf_d     = alu_ovf;
                            dbz_out_d = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            neg_lo_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            dbz_out_q <= 1'b0;
`ifdef ALU_DIV_EN
            neg_hi_q  <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_lo_q  <= neg_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_out_d;
`ifdef ALU_DIV_EN
            neg_hi_q  <= neg_hi_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    // NOTE: datapath scratch registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        work_hi_q <= work_hi_d;
        work_lo_q <= work_lo_d;
        opnd_q    <= opnd_d;
`ifdef ALU_DIV_EN
        dvd_q     <= dvd_d;
`endif
    end

    assign ALUresult   = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_out_q;
    assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed cases then random ops against an
// arithmetic reference model; follows ALU_DIV_EN like the design.
module tb_alu_muldiv;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   ctl;
    logic [W-1:0] a, b, res;
    logic         zero, ovf, dbz, busy, done;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ALUcontrol (ctl),
        .A          (a),
        .B          (b),
        .ALUresult  (res),
        .zero       (zero),
        .overflow   (ovf),
        .div_by_zero(dbz),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         dbz;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`else
        return op inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    // Reference model: plain 64-bit arithmetic, updates the HI/LO model.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, s, q, r;
        logic [63:0] pu;
        longint      smax, smin;
        smax = (longint'(1) << 31) - 1;
        smin = -(longint'(1) << 31);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = '0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0011: e.res = x ^ y;
            4'b0100: e.res = ~(x | y);
            OP_ADD: begin
                s = sx + sy;
                e.res = W'(s);
                e.ovf = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                s = sx - sy;
                e.res = W'(s);
                e.ovf = (s > smax) || (s < smin);
            end
            OP_SLT:  e.res = (sx < sy) ? 1 : 0;
            OP_SLTU: e.res = (x < y) ? 1 : 0;
            OP_MULT: begin
                s = sx * sy;
                {m_hi, m_lo} = s;
                e.res = m_lo;
            end
            OP_MULTU: begin
                pu = {32'b0, x} * {32'b0, y};
                {m_hi, m_lo} = pu;
                e.res = m_lo;
            end
`ifdef ALU_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (y == 0) begin
                    m_hi = x;
                    m_lo = '1;
                    e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = W'(q);
                    m_hi = W'(r);
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
                e.res = m_lo;
            end
`endif
            OP_MFHI: e.res = m_hi;
            OP_MFLO: e.res = m_lo;
            default: e.res = '0;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no completion (result 0x%0h)", res);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", res, mon_e.res);
                check("zero", zero, mon_e.zero);
                check("overflow", ovf, mon_e.ovf);
                check("div_by_zero", dbz, mon_e.dbz);
            end
        end
    end

    // Called at a negedge with busy low; returns at the negedge showing done.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        int cyc;
        bit multi;
        multi = is_multi(op);
        start = 1'b1;
        ctl   = op;
        a     = x;
        b     = y;
        sb_q.push_back(model(op, x, y));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ctl   = 4'($urandom);
        a     = $urandom;
        b     = $urandom;
        cyc   = 1;
        if (multi) check("busy_after_start", busy, 1);
        while (done !== 1'b1 && cyc < 3 * W) begin
            if (poke && cyc == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check(multi ? "latency_multi" : "latency_single", cyc, multi ? W + 1 : 1);
        check("busy_at_done", busy, 0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        ctl   = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", res, 0);
        check("rst_zero", zero, 1);
        check("rst_overflow", ovf, 0);
        check("rst_div_by_zero", dbz, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);

        issue(OP_MFLO, 0, 0, 0);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
        issue(OP_SUB, 5, 5, 0);
        issue(OP_SLT, 32'hFFFF_FFFF, 1, 0);
        issue(OP_SLTU, 32'hFFFF_FFFF, 1, 0);
        issue(OP_MULT, -32'sd3, 32'd7, 1);
        issue(OP_MFHI, 0, 0, 0);
        issue(OP_MFLO, 0, 0, 0);
        issue(OP_DIV, -32'sd7, 32'd2, 0);
        issue(OP_MFHI, 0, 0, 0);
        issue(OP_DIVU, 9, 0, 0);
        issue(OP_MFHI, 0, 0, 0);
        issue(OP_MFLO, 0, 0, 0);

        // Abort a long multiply with reset partway through.
        start = 1'b1;
        ctl   = OP_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'h2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", res, 0);
        check("abort_zero", zero, 1);
        rst  = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        issue(OP_MFHI, 0, 0, 0);
        issue(OP_MFLO, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
